// File: rtl/hs_burst_source.sv
// hs_burst_source
// Initiator end of the valid/ready stream interface. Accepts a burst command
// (base value, beat count minus one) and emits cmd_len+1 consecutive,
// incrementing data beats, holding valid/data/last steady while the sink stalls.
//
// Optional build macro: HS_TX_GAP_EN
//   When defined, GAP idle cycles (valid_o low) are inserted after every
//   non-last handshake. When undefined, the gap state and counter are absent
//   and the source runs at one beat per cycle.

module hs_burst_source #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_base,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    // A gap of zero cycles is meaningless; reject it at elaboration.
    generate
        if (GAP < 1) begin : g_gap_check
            $error("hs_burst_source: GAP must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
`ifdef HS_TX_GAP_EN
        ,
        ST_GAP  = 2'd2
`endif
    } state_t;

`ifdef HS_TX_GAP_EN
    // Counter holds GAP-1 down to 0, so it needs to represent GAP-1 only.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   data_r;
    logic [WIDTH-1:0]   data_s;
    logic [LEN_W-1:0]   remain_r;
    logic [LEN_W-1:0]   remain_s;
    logic               valid_r;
    logic               valid_s;
    logic               last_r;
    logic               last_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic               cmd_ready_r;
    logic               cmd_ready_s;
    logic               hs_s;
`ifdef HS_TX_GAP_EN
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_s;
`endif

    assign hs_s = valid_r && ready_i;

    // Next-state and next-output logic; every register holds unless told otherwise.
    always_comb begin
        state_s     = state_r;
        data_s      = data_r;
        remain_s    = remain_r;
        valid_s     = valid_r;
        last_s      = last_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
`ifdef HS_TX_GAP_EN
        gap_cnt_s   = gap_cnt_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    state_s  = ST_SEND;
                    data_s   = cmd_base;
                    remain_s = cmd_len;
                    valid_s  = 1'b1;
                    last_s   = (cmd_len == {LEN_W{1'b0}});
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (hs_s) begin
                    if (last_r) begin
                        // Final beat accepted: close the burst, keep data_o.
                        state_s = ST_IDLE;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        // remain_r counts beats still to come after the
                        // current one, so the next beat is last when it is 1.
                        data_s   = data_r + WIDTH'(1);
                        remain_s = remain_r - LEN_W'(1);
                        last_s   = (remain_r == LEN_W'(1));
`ifdef HS_TX_GAP_EN
                        state_s   = ST_GAP;
                        valid_s   = 1'b0;
                        gap_cnt_s = GAP_W'(GAP - 1);
`else
                        state_s   = ST_SEND;
                        valid_s   = 1'b1;
`endif
                    end
                end else begin
                    // Stalled: valid, data and last all hold.
                    state_s = ST_SEND;
                end
            end

`ifdef HS_TX_GAP_EN
            ST_GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_s = ST_SEND;
                    valid_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
`endif

            default: begin
                // Unreachable encoding: recover to a quiet idle.
                state_s  = ST_IDLE;
                valid_s  = 1'b0;
                last_s   = 1'b0;
                busy_s   = 1'b0;
                remain_s = {LEN_W{1'b0}};
            end
        endcase

        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            data_r      <= {WIDTH{1'b0}};
            remain_r    <= {LEN_W{1'b0}};
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
`ifdef HS_TX_GAP_EN
            gap_cnt_r   <= {GAP_W{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            data_r      <= data_s;
            remain_r    <= remain_s;
            valid_r     <= valid_s;
            last_r      <= last_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            cmd_ready_r <= cmd_ready_s;
`ifdef HS_TX_GAP_EN
            gap_cnt_r   <= gap_cnt_s;
`endif
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign valid_o   = valid_r;
    assign data_o    = data_r;
    assign last_o    = last_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;

endmodule

// File: tb/tb_hs_burst_source.sv
// Testbench for hs_burst_source: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the burst rules.

module tb_hs_burst_source;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;
    localparam int GAP   = 2;
`ifdef HS_TX_GAP_EN
    localparam int G = GAP;
`else
    localparam int G = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_base;
    logic [LEN_W-1:0] cmd_len;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             last_o;
    logic             busy_o;
    logic             done_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: outstanding beats of the current burst as a queue.
    logic [WIDTH-1:0] m_q[$];
    bit               m_busy;
    bit               m_valid;
    bit               m_last;
    bit               m_done;
    logic [WIDTH-1:0] m_data;
    int               m_gap;

    hs_burst_source #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (rst) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_done  = 1'b0;
            m_data  = '0;
            m_gap   = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    for (int i = 0; i <= int'(cmd_len); i++)
                        m_q.push_back(cmd_base + WIDTH'(i));
                    m_busy  = 1'b1;
                    m_valid = 1'b1;
                    m_data  = m_q[0];
                    m_last  = (m_q.size() == 1);
                end
            end else if (m_valid) begin
                if (ready_i) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_busy  = 1'b0;
                        m_valid = 1'b0;
                        m_last  = 1'b0;
                        m_done  = 1'b1;
                    end else begin
                        m_data = m_q[0];
                        m_last = (m_q.size() == 1);
                        if (G > 0) begin
                            m_valid = 1'b0;
                            m_gap   = G;
                        end
                    end
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_valid = 1'b1;
            end
        end
    endtask

    // One clock: update model, let the edge pass, compare all outputs.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("valid_o",   valid_o,   m_valid);
        check("cmd_ready", cmd_ready, !m_busy);
        check("busy_o",    busy_o,    m_busy);
        check("done_o",    done_o,    m_done);
        if (m_valid || !m_busy) begin
            check("data_o", data_o, m_data);
            check("last_o", last_o, m_last);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        ready_i   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Full-throughput burst of four beats.
        cmd_valid = 1'b1; cmd_base = 32'h0000_0010; cmd_len = 8'd3; ready_i = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (8 + 3 * G) step();

        // Five stall cycles on the first beat, then drain.
        cmd_valid = 1'b1; cmd_base = 32'h0000_0007; cmd_len = 8'd1; ready_i = 1'b0;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        ready_i = 1'b1;
        repeat (4 + G) step();

        // Toggling ready across a data wrap.
        cmd_valid = 1'b1; cmd_base = 32'hFFFF_FFFE; cmd_len = 8'd2;
        for (int i = 0; i < 14 + 2 * G; i++) begin
            ready_i = (i % 2 == 0);
            step();
            cmd_valid = 1'b0;
        end

        // cmd_valid held high: second command taken in the done cycle,
        // a third one offered while busy must be ignored.
        cmd_valid = 1'b1; cmd_base = 32'h0000_0100; cmd_len = 8'd0; ready_i = 1'b1;
        step();
        cmd_base = 32'h0000_0200; cmd_len = 8'd1;
        step();
        step();
        cmd_base = 32'h0000_0300; cmd_len = 8'd5;
        step();
        step();
        cmd_valid = 1'b0;
        repeat (3 + G) step();

        // Reset in the middle of a six-beat burst, then a clean restart.
        cmd_valid = 1'b1; cmd_base = 32'h0000_0050; cmd_len = 8'd5; ready_i = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_base = 32'h0000_0077; cmd_len = 8'd1;
        step();
        cmd_valid = 1'b0;
        repeat (4 + G) step();

        // Maximum length burst: 256 beats, no extra beat.
        cmd_valid = 1'b1; cmd_base = 32'hFFFF_FF80; cmd_len = 8'hFF; ready_i = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 260 + 255 * G; i++) step();

        // Randomized traffic with random backpressure and rare resets.
        for (int n = 0; n < 600; n++) begin
            cmd_valid = ($urandom_range(3) == 0);
            cmd_base  = $urandom();
            if ($urandom_range(7) == 0) cmd_base = 32'hFFFF_FFFC;
            cmd_len   = LEN_W'($urandom_range(6));
            if ($urandom_range(63) == 0) cmd_len = 8'hFF;
            ready_i   = ($urandom_range(2) != 0);
            rst       = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;

        // Drain whatever burst is in flight, bounded.
        cmd_valid = 1'b0;
        ready_i   = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!m_busy) break;
            step();
        end
        step();
        check("drained_busy", busy_o, 1'b0);
        check("drained_queue", m_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
